// File: rtl/or1k_dbg_pkg.sv
// Shared types and helpers for the OR1K debug-side SPR initiators.
// Holds the initiator state encoding and the GPR SPR window address builder.
package or1k_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } dbg_state_e;

  localparam logic [6:0] GPR_SPR_GROUP = 7'h2;

  function automatic logic [15:0] gpr_spr_addr(input logic [8:0] idx);
    return {GPR_SPR_GROUP, idx};
  endfunction

endpackage

// File: rtl/or1k_dbg_timeout.sv
// Loadable down-counter with an expiry flag, used to bound how long the
// initiator waits for a GPR ack.
module or1k_dbg_timeout #(
  parameter int CNT_W    = 7,
  parameter int LOAD_VAL = 63
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(LOAD_VAL);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/or1k_gpr_dbg_initiator.sv
// Debug-host SPR initiator: single GPR writes and wrapping burst reads through
// the GPR SPR window, only while the core is halted. Ack timeout: OR1K_GPR_DBG_TIMEOUT_EN.
module or1k_gpr_dbg_initiator
  import or1k_dbg_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int GPR_IDX_WIDTH        = 5,
  parameter int BURST_LEN_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES       = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_halted_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic                            cmd_we_i,
  input  logic [GPR_IDX_WIDTH-1:0]        cmd_idx_i,
  input  logic [BURST_LEN_WIDTH-1:0]      cmd_len_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] cmd_wdata_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] rsp_data_o,
  output logic                            rsp_last_o,
  output logic                            rsp_err_o,
  output logic [15:0]                     spr_bus_addr_o,
  output logic                            spr_bus_stb_o,
  output logic                            spr_bus_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
  input  logic                            spr_gpr_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i
);

  localparam int W = OPTION_OPERAND_WIDTH;

  dbg_state_e                 r_state, w_state_nxt;
  logic                       r_cmd_ready;
  logic                       r_we, w_we_nxt;
  logic [GPR_IDX_WIDTH-1:0]   r_idx, w_idx_nxt;
  logic [BURST_LEN_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0]               r_wdata, w_wdata_nxt;
  logic                       r_stb, w_stb_nxt;
  logic [15:0]                r_addr;
  logic                       r_bus_we;
  logic [W-1:0]               r_bus_dat;
  logic                       r_rsp_valid, r_rsp_last, r_rsp_err;
  logic [W-1:0]               r_rsp_data;
  logic                       w_rsp_set, w_rsp_clr, w_rsp_err;
  logic [W-1:0]               w_rsp_dat;
  logic                       w_tmo_expired;

`ifdef OR1K_GPR_DBG_TIMEOUT_EN
  logic w_tmo_load, w_tmo_dec;

  or1k_dbg_timeout #(
    .CNT_W    ($clog2(TIMEOUT_CYCLES + 1)),
    .LOAD_VAL (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_load    (w_tmo_load),
    .i_dec     (w_tmo_dec),
    .o_expired (w_tmo_expired)
  );
`else
  assign w_tmo_expired = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_stb_nxt   = 1'b0;
    w_we_nxt    = r_we;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_wdata_nxt = r_wdata;
    w_rsp_set   = 1'b0;
    w_rsp_clr   = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_dat   = '0;
`ifdef OR1K_GPR_DBG_TIMEOUT_EN
    w_tmo_load  = 1'b0;
    w_tmo_dec   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (cmd_valid_i && r_cmd_ready) begin
          w_state_nxt = ISSUE;
          w_we_nxt    = cmd_we_i;
          w_idx_nxt   = cmd_idx_i;
          w_cnt_nxt   = cmd_len_i;
          w_wdata_nxt = cmd_wdata_i;
          w_stb_nxt   = cpu_halted_i;
`ifdef OR1K_GPR_DBG_TIMEOUT_EN
          w_tmo_load  = 1'b1;
`endif
        end
      end
      ISSUE: begin
        // A completed ack takes priority over a simultaneous halt loss or expiry.
        if (r_stb && spr_gpr_ack_i) begin
          w_state_nxt = RESP;
          w_rsp_set   = 1'b1;
          w_rsp_dat   = r_we ? '0 : spr_gpr_dat_i;
        end else if (!cpu_halted_i || (r_stb && w_tmo_expired)) begin
          w_state_nxt = RESP;
          w_rsp_set   = 1'b1;
          w_rsp_err   = 1'b1;
        end else begin
          w_stb_nxt   = 1'b1;
`ifdef OR1K_GPR_DBG_TIMEOUT_EN
          w_tmo_dec   = r_stb;
`endif
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          w_rsp_clr = 1'b1;
          if (r_rsp_last) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = ISSUE;
            w_idx_nxt   = r_idx + GPR_IDX_WIDTH'(1);
            w_cnt_nxt   = r_cnt - BURST_LEN_WIDTH'(1);
            w_stb_nxt   = cpu_halted_i;
`ifdef OR1K_GPR_DBG_TIMEOUT_EN
            w_tmo_load  = 1'b1;
`endif
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == IDLE) && cpu_halted_i;
      r_we        <= w_we_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wdata     <= w_wdata_nxt;
    end
  end

  // Bus outputs are zero whenever the strobe is low, and only reload on a new beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stb     <= 1'b0;
      r_addr    <= '0;
      r_bus_we  <= 1'b0;
      r_bus_dat <= '0;
    end else begin
      r_stb     <= w_stb_nxt;
      r_addr    <= w_stb_nxt ? gpr_spr_addr(9'(w_idx_nxt)) : 16'h0000;
      r_bus_we  <= w_stb_nxt && w_we_nxt;
      r_bus_dat <= (w_stb_nxt && w_we_nxt) ? w_wdata_nxt : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (w_rsp_set) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rsp_dat;
      r_rsp_last  <= w_rsp_err || r_we || (r_cnt == '0);
      r_rsp_err   <= w_rsp_err;
    end else if (w_rsp_clr) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end
  end

  assign cmd_ready_o    = r_cmd_ready;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_data_o     = r_rsp_data;
  assign rsp_last_o     = r_rsp_last;
  assign rsp_err_o      = r_rsp_err;
  assign spr_bus_addr_o = r_addr;
  assign spr_bus_stb_o  = r_stb;
  assign spr_bus_we_o   = r_bus_we;
  assign spr_bus_dat_o  = r_bus_dat;

endmodule

// File: tb/tb_or1k_gpr_dbg_initiator.sv
// Self-checking bench for or1k_gpr_dbg_initiator: directed vector table,
// hand-written halt-loss / timeout / reset sequences and a randomized phase.
module tb_or1k_gpr_dbg_initiator;

  localparam int DW  = 32;
  localparam int IW  = 5;
  localparam int LW  = 5;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_halted_i, cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [IW-1:0] cmd_idx_i;
  logic [LW-1:0] cmd_len_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_last_o, rsp_err_o;
  logic [DW-1:0] rsp_data_o;
  logic [15:0]   spr_bus_addr_o;
  logic          spr_bus_stb_o, spr_bus_we_o, spr_gpr_ack_i;
  logic [DW-1:0] spr_bus_dat_o, spr_gpr_dat_i;

  always #5 clk = ~clk;

  or1k_gpr_dbg_initiator #(
    .OPTION_OPERAND_WIDTH (DW),
    .GPR_IDX_WIDTH        (IW),
    .BURST_LEN_WIDTH      (LW),
    .TIMEOUT_CYCLES       (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_halted_i   (cpu_halted_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_we_i       (cmd_we_i),
    .cmd_idx_i      (cmd_idx_i),
    .cmd_len_i      (cmd_len_i),
    .cmd_wdata_i    (cmd_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .rsp_last_o     (rsp_last_o),
    .rsp_err_o      (rsp_err_o),
    .spr_bus_addr_o (spr_bus_addr_o),
    .spr_bus_stb_o  (spr_bus_stb_o),
    .spr_bus_we_o   (spr_bus_we_o),
    .spr_bus_dat_o  (spr_bus_dat_o),
    .spr_gpr_ack_i  (spr_gpr_ack_i),
    .spr_gpr_dat_i  (spr_gpr_dat_i)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [31:0] dat;
    bit          unst;
  } bus_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
    int          vstart;
    bit          unst;
  } rsp_t;

  typedef struct {
    bit          we;
    int          idx;
    int          len;
    logic [31:0] wd;
    int          dly;
    int          rdy;
    int          exp_lat;
    logic [15:0] exp_first_addr;
    logic [15:0] exp_last_addr;
    logic [31:0] exp_last_data;
  } vec_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ack_delay = 1;
  bit   ack_inject = 1'b0;
  int   rdy_mode = 0;
  int   stall_beat = 0;
  int   stall_left = 0;
  int   overlap = 0;
  bit   bus_unst = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // GPR-side responder: acks ack_delay cycles after the strobe rises, data 0x100+index.
  initial begin
    int          age;
    logic [15:0] f_addr;
    logic        f_we;
    logic [31:0] f_dat;
    age = 0;
    spr_gpr_ack_i = 1'b0;
    spr_gpr_dat_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (spr_bus_stb_o) begin
        age++;
        if (age == 1) begin
          f_addr = spr_bus_addr_o; f_we = spr_bus_we_o; f_dat = spr_bus_dat_o; bus_unst = 1'b0;
        end else if (spr_bus_addr_o !== f_addr || spr_bus_we_o !== f_we || spr_bus_dat_o !== f_dat) begin
          bus_unst = 1'b1;
        end
        spr_gpr_ack_i = (age == ack_delay + 1) || ack_inject;
      end else begin
        age = 0;
        spr_gpr_ack_i = ack_inject;
      end
      spr_gpr_dat_i = spr_gpr_ack_i ? 32'h100 + {23'b0, spr_bus_addr_o[8:0]} : 32'h0;
    end
  end

  initial begin
    rsp_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: rsp_ready_i = 1'($urandom_range(0, 1));
        2: begin
          if (rsp_valid_o && rsp_q.size() == stall_beat && stall_left > 0) begin
            rsp_ready_i = 1'b0;
            stall_left--;
          end else begin
            rsp_ready_i = 1'b1;
          end
        end
        default: rsp_ready_i = 1'b1;
      endcase
    end
  end

  // Monitors: completed bus transfers and response handshakes.
  initial begin
    bit          pv;
    int          vs;
    bit          ru;
    logic [33:0] held;
    pv = 1'b0; vs = 0; ru = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 1'b0;
      end else begin
        if (spr_bus_stb_o && spr_gpr_ack_i)
          bus_q.push_back('{spr_bus_addr_o, spr_bus_we_o, spr_bus_dat_o, bus_unst});
        if (spr_bus_stb_o && rsp_valid_o) overlap++;
        if (rsp_valid_o) begin
          if (!pv) begin
            vs = cyc;
            ru = 1'b0;
          end else if ({rsp_data_o, rsp_last_o, rsp_err_o} !== held) begin
            ru = 1'b1;
          end
          held = {rsp_data_o, rsp_last_o, rsp_err_o};
          if (rsp_ready_i) begin
            rsp_q.push_back('{rsp_data_o, rsp_last_o, rsp_err_o, vs, ru});
            pv = 1'b0;
          end else begin
            pv = 1'b1;
          end
        end else begin
          pv = 1'b0;
        end
      end
    end
  end

  task automatic send_cmd(input bit we, input int idx, input int len, input logic [31:0] wd,
                          input int dly, output int acc);
    bit got;
    bus_q.delete();
    rsp_q.delete();
    ack_delay = dly;
    acc = -1;
    got = 1'b0;
    @(posedge clk);
    #1;
    cmd_we_i = we; cmd_idx_i = IW'(idx); cmd_len_i = LW'(len); cmd_wdata_i = wd;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    chk("cmd_accept", 64'(got), 64'd1);
  endtask

  task automatic run_cmd(input bit we, input int idx, input int len, input logic [31:0] wd,
                         input int dly, output int acc);
    int nb;
    int n;
    nb = we ? 1 : len + 1;
    send_cmd(we, idx, len, wd, dly, acc);
    n = 0;
    while (rsp_q.size() < nb && n < 600) begin
      @(posedge clk);
      n++;
    end
    chk("cmd_complete_in_budget", 64'(rsp_q.size() >= nb), 64'd1);
    repeat (3) @(posedge clk);
  endtask

  // Reference: beat i touches GPR (idx+i) mod 32; reads return 0x100+GPR; writes one beat.
  task automatic check_cmd(input bit we, input int idx, input int len, input logic [31:0] wd,
                           input int acc, input int exp_lat);
    int          nb;
    int          ix;
    logic [15:0] ea;
    logic [31:0] ed;
    nb = we ? 1 : len + 1;
    chk("bus_beats", 64'(bus_q.size()), 64'(nb));
    chk("rsp_beats", 64'(rsp_q.size()), 64'(nb));
    for (int i = 0; i < nb; i++) begin
      ix = (idx + i) % 32;
      ea = 16'h0400 + 16'(ix);
      ed = we ? 32'h0 : 32'h100 + 32'(ix);
      if (i < bus_q.size()) begin
        chk("bus_addr_we", 64'({bus_q[i].addr, bus_q[i].we}), 64'({ea, we}));
        if (we) chk("bus_wdata", 64'(bus_q[i].dat), 64'(wd));
        chk("bus_stable", 64'(bus_q[i].unst), 64'd0);
      end
      if (i < rsp_q.size())
        chk("rsp_beat", 64'({rsp_q[i].data, rsp_q[i].last, rsp_q[i].err, rsp_q[i].unst}),
            64'({ed, (i == nb - 1), 1'b0, 1'b0}));
    end
    if (exp_lat >= 0 && rsp_q.size() > 0)
      chk("first_rsp_latency", 64'(rsp_q[0].vstart - acc), 64'(exp_lat));
  endtask

  initial begin
    vec_t vecs[6];
    int   acc;
    int   cnt;
    bit   flag;

    vecs[0] = '{1'b1,  3, 0, 32'hDEADBEEF,  0, 0,  2, 16'h0403, 16'h0403, 32'h0};
    vecs[1] = '{1'b0, 30, 3, 32'h0,         1, 0,  3, 16'h041E, 16'h0401, 32'h101};
    vecs[2] = '{1'b0,  5, 2, 32'h0,         1, 2,  3, 16'h0405, 16'h0407, 32'h107};
    vecs[3] = '{1'b1, 17, 0, 32'h12345678, 10, 0, 12, 16'h0411, 16'h0411, 32'h0};
    vecs[4] = '{1'b0, 31, 1, 32'h0,         0, 0,  2, 16'h041F, 16'h0400, 32'h100};
    vecs[5] = '{1'b0,  0, 0, 32'h0,        10, 0, 12, 16'h0400, 16'h0400, 32'h100};

    rst = 1'b0;
    cpu_halted_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_idx_i = '0; cmd_len_i = '0; cmd_wdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'({cmd_ready_o, rsp_valid_o, rsp_last_o, rsp_err_o, spr_bus_stb_o, spr_bus_we_o}), 64'd0);
    chk("reset_addr", 64'(spr_bus_addr_o), 64'd0);
    chk("reset_data", 64'({rsp_data_o, spr_bus_dat_o}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(cmd_ready_o), 64'd1);

    // Stray ack while idle must not produce anything.
    ack_inject = 1'b1;
    flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid_o || spr_bus_stb_o) flag = 1'b1;
    end
    ack_inject = 1'b0;
    @(negedge clk);
    chk("idle_ack_ignored", 64'({flag, rsp_valid_o}), 64'd0);

    for (int v = 0; v < 6; v++) begin
      rdy_mode = vecs[v].rdy;
      stall_beat = 1;
      stall_left = 5;
      run_cmd(vecs[v].we, vecs[v].idx, vecs[v].len, vecs[v].wd, vecs[v].dly, acc);
      check_cmd(vecs[v].we, vecs[v].idx, vecs[v].len, vecs[v].wd, acc, vecs[v].exp_lat);
      if (bus_q.size() > 0 && rsp_q.size() > 0) begin
        chk("vec_first_addr", 64'(bus_q[0].addr), 64'(vecs[v].exp_first_addr));
        chk("vec_last_addr", 64'(bus_q[bus_q.size()-1].addr), 64'(vecs[v].exp_last_addr));
        chk("vec_last_data", 64'(rsp_q[rsp_q.size()-1].data), 64'(vecs[v].exp_last_data));
      end
    end
    rdy_mode = 0;

    // Halt loss during the second beat of a 4-beat read.
    send_cmd(1'b0, 8, 3, 32'h0, 1, acc);
    flag = 1'b0;
    for (int i = 0; i < 50 && !flag; i++) begin
      @(negedge clk);
      if (spr_bus_stb_o && !spr_gpr_ack_i && bus_q.size() == 1) begin
        flag = 1'b1;
        cpu_halted_i = 1'b0;
      end
    end
    chk("halt_second_beat_seen", 64'(flag), 64'd1);
    @(negedge clk);
    chk("halt_stb_dropped", 64'(spr_bus_stb_o), 64'd0);
    chk("halt_err_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_last_o, rsp_data_o}), 64'({3'b111, 32'h0}));
    flag = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (spr_bus_stb_o || rsp_valid_o || cmd_ready_o) flag = 1'b1;
    end
    chk("halt_quiet_idle", 64'(flag), 64'd0);
    chk("halt_counts", 64'({8'(bus_q.size()), 8'(rsp_q.size())}), 64'({8'd1, 8'd2}));
    if (rsp_q.size() == 2) begin
      chk("halt_beat0", 64'({rsp_q[0].data, rsp_q[0].last, rsp_q[0].err}), 64'({32'h108, 2'b00}));
      chk("halt_beat1", 64'({rsp_q[1].data, rsp_q[1].last, rsp_q[1].err}), 64'({32'h0, 2'b11}));
    end
    cpu_halted_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_halt_return", 64'(cmd_ready_o), 64'd1);

    for (int r = 0; r < 30; r++) begin
      bit          we;
      int          idx, len, dly;
      logic [31:0] wd;
      we  = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 31));
      len = int'($urandom_range(0, 7));
      wd  = $urandom;
      dly = we ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
      rdy_mode = int'($urandom_range(0, 1));
      run_cmd(we, idx, len, wd, dly, acc);
      check_cmd(we, idx, len, wd, acc, 2 + dly);
    end
    rdy_mode = 0;

    send_cmd(1'b0, 2, 3, 32'h0, 1000000, acc);
`ifdef OR1K_GPR_DBG_TIMEOUT_EN
    cnt = 0;
    flag = 1'b0;
    for (int i = 0; i < 200 && !flag; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        flag = 1'b1;
        chk("timeout_rsp", 64'({rsp_err_o, rsp_last_o, rsp_data_o}), 64'({2'b11, 32'h0}));
      end else if (spr_bus_stb_o) begin
        cnt++;
      end
    end
    chk("timeout_seen", 64'(flag), 64'd1);
    chk("timeout_stb_cycles", 64'(cnt), 64'(TMO));
    flag = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (spr_bus_stb_o || rsp_valid_o) flag = 1'b1;
    end
    chk("timeout_burst_aborted", 64'({flag, 8'(rsp_q.size())}), 64'({1'b0, 8'd1}));
`else
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (spr_bus_stb_o && !rsp_valid_o) cnt++;
    end
    chk("no_timeout_stb_held", 64'(cnt), 64'd100);
`endif
    // Async reset mid-transfer (or while idle after a timeout) loses everything.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_reset_stb", 64'({spr_bus_stb_o, rsp_valid_o, spr_bus_addr_o}), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    rsp_q.delete();
    repeat (3) @(negedge clk);
    chk("after_reset_idle", 64'({cmd_ready_o, spr_bus_stb_o, rsp_valid_o, 8'(rsp_q.size())}),
        64'({1'b1, 1'b0, 1'b0, 8'd0}));

    chk("no_stb_during_rsp", 64'(overlap), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
